// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: memory-op codes, branch condition
// codes, NZCV bit positions and the stage FSM state type.
package mem_stage_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [3:0] BR_NONE   = 4'b0000;
  localparam logic [3:0] BR_ALWAYS = 4'b0001;
  localparam logic [3:0] BR_EQ     = 4'b0010;
  localparam logic [3:0] BR_NE     = 4'b0011;
  localparam logic [3:0] BR_LT     = 4'b0100;
  localparam logic [3:0] BR_GE     = 4'b0101;
  localparam logic [3:0] BR_CS     = 4'b0110;
  localparam logic [3:0] BR_CC     = 4'b0111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_branch_cond_eval.sv
// Combinational branch resolution: decides whether a condition code is
// satisfied by the given NZCV flags.
module branch_cond_eval
  import mem_stage_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] code,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (code)
      BR_ALWAYS: taken = 1'b1;
      BR_EQ:     taken = flags[FLAG_Z];
      BR_NE:     taken = ~flags[FLAG_Z];
      BR_LT:     taken = flags[FLAG_N] ^ flags[FLAG_V];
      BR_GE:     taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      BR_CS:     taken = flags[FLAG_C];
      BR_CC:     taken = ~flags[FLAG_C];
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: load/store over a req/ack port with timeout,
// branch resolution against the NZCV register, and the writeback latch.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [5:0]  ex_rd,
  input  logic [1:0]  ex_mem_op,
  input  logic [3:0]  ex_branch,
  input  logic [31:0] ex_new_pc,
  input  logic        ex_set_cond,
  input  logic [3:0]  ex_cond,
  output logic [3:0]  alu_cond,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_fault,
  output logic        wb_valid,
  output logic [5:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [3:0]  flags;
  logic [7:0]  tmo_cnt;
  logic [5:0]  acc_rd;
  logic        acc_we;
  logic        br_taken;
  logic        accept;
  logic        is_mem;

  branch_cond_eval u_branch_cond_eval (
    .flags (flags),
    .code  (ex_branch),
    .taken (br_taken)
  );

  // A redirect pulse marks the shadow cycle; its instruction is squashed.
  assign accept   = (state == ST_IDLE) && ex_valid && !redirect_valid;
  assign is_mem   = (ex_mem_op == MEM_LOAD) || (ex_mem_op == MEM_STORE);

  assign alu_cond = flags;
  assign stall    = (state == ST_ACCESS);
  assign mem_req  = (state == ST_ACCESS);
  assign mem_we   = (state == ST_ACCESS) && acc_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      flags          <= '0;
      tmo_cnt        <= '0;
      acc_rd         <= '0;
      acc_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mem_fault      <= 1'b0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
    end else begin
      wb_valid       <= 1'b0;
      redirect_valid <= 1'b0;
      mem_fault      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mem) begin
              if (ex_alu_result[1:0] != 2'b00) begin
                mem_fault <= 1'b1;
              end else begin
                mem_addr  <= ex_alu_result;
                mem_wdata <= ex_store_data;
                acc_rd    <= ex_rd;
                acc_we    <= (ex_mem_op == MEM_STORE);
                tmo_cnt   <= '0;
                state     <= ST_ACCESS;
              end
            end else begin
              wb_valid <= (ex_rd != '0);
              wb_rd    <= ex_rd;
              wb_data  <= ex_alu_result;
              if (ex_set_cond) flags <= ex_cond;
              if (br_taken) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= ex_new_pc;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            if (!acc_we) begin
              wb_valid <= (acc_rd != '0);
              wb_rd    <= acc_rd;
              wb_data  <= mem_rdata;
            end
            state <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_fault <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU writeback, flags/branch,
// squash, load wait states, misalignment, timeout and mid-access reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [5:0]  ex_rd;
  logic [1:0]  ex_mem_op;
  logic [3:0]  ex_branch;
  logic [31:0] ex_new_pc;
  logic        ex_set_cond;
  logic [3:0]  ex_cond;
  logic [3:0]  alu_cond;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_fault;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mem_stage #(.ACK_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_mem_op      (ex_mem_op),
    .ex_branch      (ex_branch),
    .ex_new_pc      (ex_new_pc),
    .ex_set_cond    (ex_set_cond),
    .ex_cond        (ex_cond),
    .alu_cond       (alu_cond),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .mem_fault      (mem_fault),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned stall_cycles;
    int unsigned req_cycles;

    rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
    ex_rd = '0; ex_mem_op = 2'b00; ex_branch = 4'b0000; ex_new_pc = '0;
    ex_set_cond = 1'b0; ex_cond = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_flags", 32'(alu_cond), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    tick();

    // ALU op with rd=5
    ex_valid = 1'b1; ex_rd = 6'd5; ex_alu_result = 32'h1234;
    tick();
    chk("alu_wb_valid", 32'(wb_valid), 32'd1);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_stall", 32'(stall), 32'd0);

    // ALU op with rd=0 never writes back
    ex_rd = 6'd0; ex_alu_result = 32'h55;
    tick();
    chk("rd0_wb_valid", 32'(wb_valid), 32'd0);

    // Set Z flag
    ex_set_cond = 1'b1; ex_cond = 4'b0100;
    tick();
    chk("setz_flags", 32'(alu_cond), 32'h4);

    // BEQ taken to 0x100
    ex_set_cond = 1'b0; ex_branch = 4'b0010; ex_new_pc = 32'h100;
    ex_rd = 6'd7; ex_alu_result = 32'h77;
    tick();
    chk("beq_redirect", 32'(redirect_valid), 32'd1);
    chk("beq_pc", redirect_pc, 32'h100);
    chk("beq_wb_valid", 32'(wb_valid), 32'd1);

    // Shadow-cycle instruction squashed
    ex_branch = 4'b0000; ex_rd = 6'd9; ex_alu_result = 32'h99;
    ex_set_cond = 1'b1; ex_cond = 4'b1111;
    tick();
    chk("squash_wb_valid", 32'(wb_valid), 32'd0);
    chk("squash_redirect", 32'(redirect_valid), 32'd0);
    chk("squash_flags", 32'(alu_cond), 32'h4);

    // BNE with Z set is not taken
    ex_set_cond = 1'b0; ex_branch = 4'b0011; ex_rd = 6'd0;
    tick();
    chk("bne_not_taken", 32'(redirect_valid), 32'd0);

    // Load from 0x40, ack on the fourth access cycle
    ex_branch = 4'b0000; ex_mem_op = 2'b01; ex_alu_result = 32'h40;
    ex_rd = 6'd3; ex_set_cond = 1'b1; ex_cond = 4'b1111;
    tick();
    ex_valid = 1'b0; ex_set_cond = 1'b0;
    chk("ld_mem_req", 32'(mem_req), 32'd1);
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    chk("ld_mem_addr", mem_addr, 32'h40);
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      end
      if (stall) stall_cycles++;
      tick();
    end
    mem_ack = 1'b0;
    chk("ld_stall_cycles", stall_cycles, 32'd4);
    chk("ld_wb_valid", 32'(wb_valid), 32'd1);
    chk("ld_wb_rd", 32'(wb_rd), 32'd3);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_req_done", 32'(mem_req), 32'd0);
    chk("ld_no_flags", 32'(alu_cond), 32'h4);

    // Misaligned store to 0x42
    ex_valid = 1'b1; ex_mem_op = 2'b10; ex_alu_result = 32'h42;
    tick();
    ex_valid = 1'b0;
    chk("mis_fault", 32'(mem_fault), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    tick();
    chk("mis_fault_pulse", 32'(mem_fault), 32'd0);
    chk("mis_req_after", 32'(mem_req), 32'd0);

    // Load with no ack times out after 16 request cycles
    ex_valid = 1'b1; ex_mem_op = 2'b01; ex_alu_result = 32'h80; ex_rd = 6'd4;
    tick();
    ex_valid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      req_cycles++;
      tick();
    end
    chk("tmo_req_cycles", req_cycles, 32'd16);
    chk("tmo_fault", 32'(mem_fault), 32'd1);
    chk("tmo_wb_valid", 32'(wb_valid), 32'd0);
    chk("tmo_stall", 32'(stall), 32'd0);

    // Aligned store, zero-wait ack
    ex_valid = 1'b1; ex_mem_op = 2'b10; ex_alu_result = 32'h44;
    ex_store_data = 32'hAA55;
    tick();
    ex_valid = 1'b0;
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_addr", mem_addr, 32'h44);
    chk("st_mem_wdata", mem_wdata, 32'hAA55);
    mem_ack = 1'b1;
    tick();
    chk("st_wb_valid", 32'(wb_valid), 32'd0);
    chk("st_req_done", 32'(mem_req), 32'd0);

    // Ack while idle is ignored
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    chk("idle_ack_wb", 32'(wb_valid), 32'd0);

    // Reset during access
    ex_valid = 1'b1; ex_mem_op = 2'b01; ex_alu_result = 32'h48; ex_rd = 6'd2;
    tick();
    ex_valid = 1'b0;
    chk("rstacc_req_before", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstacc_req", 32'(mem_req), 32'd0);
    chk("rstacc_stall", 32'(stall), 32'd0);
    chk("rstacc_flags", 32'(alu_cond), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstacc_idle", 32'(mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline: consumes the execute-stage latch, performs load/store through a request/acknowledge data-memory port, resolves branches against the condition-flag register and issues PC redirects. It owns the NZCV flag register whose value feeds back to the execute stage as `alu_cond`, and registers results into the writeback latch.

## Interface
- `ACK_TIMEOUT`, 16: cycles in ACCESS without `mem_ack` before abort with fault; range 2..255.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ex_valid`  in  1  execute latch holds an instruction.
- `ex_alu_result`  in  32  ALU result / effective address.
- `ex_store_data`  in  32  store data.
- `ex_rd`  in  6  destination register.
- `ex_mem_op`  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- `ex_branch`  in  4  branch condition code.
- `ex_new_pc`  in  32  branch target from the branch adder.
- `ex_set_cond`  in  1  update flags with `ex_cond`.
- `ex_cond`  in  4  NZCV from the ALU (bit3 N, bit2 Z, bit1 C, bit0 V).
- `alu_cond`  out  4  current flag register to execute stage.
- `stall`  out  1  execute latch must hold.
- `redirect_valid`  out  1  one-cycle redirect pulse.
- `redirect_pc`  out  32  redirect target.
- `mem_req`, `mem_we`  out  1 each  request, write enable.
- `mem_addr`, `mem_wdata`  out  32 each.
- `mem_rdata`  in  32;  `mem_ack`  in  1  request complete.
- `mem_fault`  out  1  one-cycle pulse: misaligned access or timeout.
- `wb_valid`  out  1;  `wb_rd`  out  6;  `wb_data`  out  32  writeback latch.

## Operation
- FSM states IDLE, ACCESS. Reset: IDLE; all outputs 0, flags 4'b0000.
- Accept: IDLE and `ex_valid` and not shadow cycle (cycle in which `redirect_valid` is 1). Shadow-cycle instruction is squashed: no flag update, no writeback, no memory request.
- Non-memory op on accept: `wb_valid`<=(`ex_rd`!=0), `wb_rd`<=`ex_rd`, `wb_data`<=`ex_alu_result`; flags<=`ex_cond` if `ex_set_cond`.
- Branch codes (only when `ex_mem_op` is none): 0000 none, 0001 always, 0010 EQ (Z), 0011 NE (!Z), 0100 LT (N^V), 0101 GE (!(N^V)), 0110 CS (C), 0111 CC (!C), others none. Evaluated against flag value before this instruction's update. Taken: `redirect_valid`<=1, `redirect_pc`<=`ex_new_pc`.
- Load/store on accept: if `ex_alu_result[1:0]`!=0: `mem_fault` pulse, no request, `wb_valid`<=0, stay IDLE. Else capture addr/data/rd/op, enter ACCESS, timeout counter<=0.
- ACCESS: `mem_req`=1, `mem_we`=(op==store), `mem_addr`/`mem_wdata` stable; `stall`=1. On `mem_ack`: load -> `wb_valid`<=(rd!=0), `wb_data`<=`mem_rdata`; store -> `wb_valid`<=0; return IDLE. Counter reaching `ACK_TIMEOUT`-1 without ack: `mem_fault` pulse, `wb_valid`<=0, IDLE.
- `mem_ack` in IDLE ignored. Memory ops never update flags.
- Cycles with no accept: `wb_valid`<=0, `redirect_valid`<=0.

## Timing
- `stall`, `mem_req`, `mem_we` decoded from registered state (no combinational path from `ex_*`).
- Non-memory op: latency 1 (accept edge N -> `wb_*`/`redirect_*` valid after N).
- Load: accept N, `mem_req` high from N+1; ack sampled at edge M -> `wb_valid` after M, `mem_req` low after M; next accept possible at M+1.
- Zero-wait memory (ack in first ACCESS cycle): load occupies 2 cycles.
- `alu_cond` reflects new flags the cycle after the updating accept.
- `rst` mid-ACCESS drops `mem_req` immediately; pending access discarded.

## Structure
- `mem_stage_pkg`: mem-op codes, branch condition codes, NZCV bit indices, FSM state type.
- Sub-module `branch_cond_eval`: combinational (flags, code) -> taken.

## Test plan
- ALU op rd=5, result 32'h1234 -> next cycle `wb_valid`=1, `wb_rd`=5, `wb_data`=32'h1234; rd=0 -> `wb_valid`=0.
- `ex_set_cond` with cond 4'b0100, then BEQ to 32'h100 -> `redirect_valid` pulse, `redirect_pc`=32'h100; following instruction squashed (no writeback).
- Load addr 32'h40, ack after 3 wait cycles, rdata 32'hDEADBEEF -> `stall` high 4 cycles, `wb_data`=32'hDEADBEEF.
- Store to 32'h42 -> `mem_fault` pulse, `mem_req` never asserted.
- Load with no ack -> `mem_req` high exactly 16 cycles, then `mem_fault` pulse, IDLE, `wb_valid`=0.
- `rst` asserted during ACCESS -> `mem_req`, `stall` low same cycle, flags 0.
